// File: rtl/nv_fifo_ctrl_80x15_if.sv
// ---------------------------------------------------------------------------
// nv_fifo_ctrl_80x15_if
//   Valid/ready handshake bundle for the 80x15 FIFO controller.
//   Write side : wr_pvld / wr_prdy / wr_pd  (producer -> FIFO)
//   Read side  : rd_pvld / rd_prdy / rd_pd  (FIFO -> consumer)
//   Modports:
//     slave  - the FIFO controller (accepts writes, offers reads)
//     master - the surrounding logic (producer and consumer)
// ---------------------------------------------------------------------------
interface nv_fifo_ctrl_80x15_if;
  logic        wr_pvld;
  logic        wr_prdy;
  logic [14:0] wr_pd;
  logic        rd_pvld;
  logic        rd_prdy;
  logic [14:0] rd_pd;

  modport slave (
    input  wr_pvld, wr_pd, rd_prdy,
    output wr_prdy, rd_pvld, rd_pd
  );

  modport master (
    output wr_pvld, wr_pd, rd_prdy,
    input  wr_prdy, rd_pvld, rd_pd
  );
endinterface

// File: rtl/nv_fifo_ctrl_80x15.sv
// ---------------------------------------------------------------------------
// nv_fifo_ctrl_80x15
//   Valid/ready FIFO controller for an external 80x15 RAM macro with a
//   registered read address (stage 1) and a registered output (stage 2).
//   The RAM output register is the FIFO head, so no extra data flops exist.
//
//   Ports:
//     nvdla_core_clk     - clock (also clocks the attached RAM)
//     nvdla_core_rstn    - asynchronous active-low reset
//     fifo_if            - write/read handshake bundle (slave modport)
//     fifo_count[6:0]    - occupancy 0..80, including both pipeline stages
//     ram_wa/we/di       - RAM write port
//     ram_ra/re/ore      - RAM read address, address-register enable,
//                          output-register enable
//     ram_byp_sel/dbyp   - RAM bypass, unused, tied to 0
//     ram_dout           - RAM registered output, returned as rd_pd
//     pwrbus_ram_pd      - power control, forwarded to ram_pwrbus_ram_pd
// ---------------------------------------------------------------------------
module nv_fifo_ctrl_80x15 (
  input  logic                    nvdla_core_clk,
  input  logic                    nvdla_core_rstn,
  nv_fifo_ctrl_80x15_if.slave     fifo_if,
  output logic [6:0]              fifo_count,
  output logic [6:0]              ram_wa,
  output logic                    ram_we,
  output logic [14:0]             ram_di,
  output logic [6:0]              ram_ra,
  output logic                    ram_re,
  output logic                    ram_ore,
  output logic                    ram_byp_sel,
  output logic [14:0]             ram_dbyp,
  input  logic [14:0]             ram_dout,
  input  logic [31:0]             pwrbus_ram_pd,
  output logic [31:0]             ram_pwrbus_ram_pd
);

  localparam logic [6:0] DEPTH    = 7'd80;
  localparam logic [6:0] LAST_IDX = 7'd79;

  logic [6:0] wr_ptr_q, wr_ptr_d;
  logic [6:0] rd_ptr_q, rd_ptr_d;
  logic [6:0] count_q,  count_d;
  logic [6:0] unread_q, unread_d;
  logic       s1_vld_q, s1_vld_d;
  logic       s2_vld_q, s2_vld_d;

  logic       push;
  logic       pop;
  logic       re;
  logic       ore;

  // Pointers wrap 79 -> 0; values 80..127 are never produced.
  function automatic logic [6:0] ptr_inc(input logic [6:0] p);
    return (p == LAST_IDX) ? 7'd0 : p + 7'd1;
  endfunction

  // -------------------------------------------------------------------------
  // Handshake and RAM control.
  // The full test uses count (which includes stage-1/stage-2 entries), so a
  // slot cannot be rewritten before its data has left the RAM array. A pop
  // at full does not reopen wr_prdy in the same cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    fifo_if.wr_prdy = (count_q != DEPTH);
    push            = fifo_if.wr_pvld & fifo_if.wr_prdy;

    fifo_if.rd_pvld = s2_vld_q;
    fifo_if.rd_pd   = ram_dout;
    pop             = s2_vld_q & fifo_if.rd_prdy;

    // Stage 2 loads when it is empty or being drained this cycle.
    ore = s1_vld_q & (~s2_vld_q | fifo_if.rd_prdy);
    // Stage 1 loads when RAM holds an unissued entry and stage 1 is free or
    // moving forward; during a head stall both enables stay low and hold.
    re  = (unread_q != 7'd0) & (~s1_vld_q | ore);
  end

  assign ram_we            = push;
  assign ram_wa            = wr_ptr_q;
  assign ram_di            = fifo_if.wr_pd;
  assign ram_re            = re;
  assign ram_ra            = rd_ptr_q;
  assign ram_ore           = ore;
  assign ram_byp_sel       = 1'b0;
  assign ram_dbyp          = 15'd0;
  assign ram_pwrbus_ram_pd = pwrbus_ram_pd;
  assign fifo_count        = count_q;

  // -------------------------------------------------------------------------
  // Next-state logic.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    unread_d = unread_q;

    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (re)   rd_ptr_d = ptr_inc(rd_ptr_q);

    unique case ({push, pop})
      2'b10:   count_d = count_q + 7'd1;
      2'b01:   count_d = count_q - 7'd1;
      default: count_d = count_q;
    endcase

    unique case ({push, re})
      2'b10:   unread_d = unread_q + 7'd1;
      2'b01:   unread_d = unread_q - 7'd1;
      default: unread_d = unread_q;
    endcase

    s1_vld_d = re  | (s1_vld_q & ~ore);
    s2_vld_d = ore | (s2_vld_q & ~fifo_if.rd_prdy);
  end

  // -------------------------------------------------------------------------
  // State registers. Only control state is reset; RAM contents and its
  // output register are left alone, so rd_pd is undefined until rd_pvld.
  // -------------------------------------------------------------------------
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_q <= 7'd0;
      rd_ptr_q <= 7'd0;
      count_q  <= 7'd0;
      unread_q <= 7'd0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      unread_q <= unread_d;
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
    end
  end

endmodule
